// File: rtl/dma_copy_engine_pkg.sv
// Shared definitions for the DMA copy engine and the peripherals on the data bus.
// Holds the bus mode encoding and the engine state type.
package dma_copy_engine_pkg;

  // Bus mode encoding seen by every memory-mapped peripheral.
  localparam logic [1:0] BUS_IDLE  = 2'b00;
  localparam logic [1:0] BUS_READ  = 2'b01;
  localparam logic [1:0] BUS_WRITE = 2'b10;

  // Engine states: one READ and one WRITE bus cycle per copied word.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

endpackage

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: bus initiator that copies a block of 32-bit words from a
// source range to a destination range, one read then one write per word.
// The bus is driven only while bus_grant is high; a dropped grant stalls the
// engine in place without losing the buffered word.
// Optional feature: define DMA_FILL_EN to add fill_mode/fill_value, which skip
// the read cycle and write fill_value to every destination word.
module dma_copy_engine
  import dma_copy_engine_pkg::*;
#(
  parameter logic [31:0] ADDR_STRIDE = 32'd4,
  parameter int          COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        src_addr,
  input  logic [31:0]        dst_addr,
  input  logic [COUNT_W-1:0] word_count,
  input  logic               irq_ack,
`ifdef DMA_FILL_EN
  input  logic               fill_mode,
  input  logic [31:0]        fill_value,
`endif
  input  logic               bus_grant,
  output logic               bus_req,
  output logic               busy,
  output logic               done,
  output logic               dma_irq,
  output logic [31:0]        data_bus_addr,
  output logic [1:0]         data_bus_mode,
  inout  wire  [31:0]        data_bus_data
);

  dma_state_t         state_reg, state_next;
  logic [31:0]        src_reg;
  logic [31:0]        dst_reg;
  logic [31:0]        buffer_reg;
  logic [COUNT_W-1:0] remaining_reg;
  logic               irq_reg;
  logic               drive_en;
  logic [31:0]        write_data;
  logic               fill_req;   // fill requested on the start being accepted
  logic               fill_sel;   // fill active for the current transfer
  logic               start_ok;

  assign start_ok = (state_reg == IDLE) && start;

`ifdef DMA_FILL_EN
  logic        fill_reg;
  logic [31:0] fill_value_reg;

  assign fill_req   = fill_mode;
  assign fill_sel   = fill_reg;
  assign write_data = fill_reg ? fill_value_reg : buffer_reg;

  // Latch the fill configuration together with the other transfer parameters.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_reg       <= 1'b0;
      fill_value_reg <= '0;
    end else if (start_ok && (word_count != '0)) begin
      fill_reg       <= fill_mode;
      fill_value_reg <= fill_value;
    end
  end
`else
  assign fill_req   = 1'b0;
  assign fill_sel   = 1'b0;
  assign write_data = buffer_reg;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and bus outputs; nothing reaches the bus unless granted.
  always_comb begin
    state_next    = state_reg;
    bus_req       = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    data_bus_mode = BUS_IDLE;
    data_bus_addr = '0;
    drive_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (word_count == '0) begin
            state_next = DONE;
          end else if (fill_req) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      READ: begin
        bus_req = 1'b1;
        if (bus_grant) begin
          data_bus_mode = BUS_READ;
          data_bus_addr = src_reg;
          state_next    = WRITE;
        end
      end
      WRITE: begin
        bus_req = 1'b1;
        if (bus_grant) begin
          data_bus_mode = BUS_WRITE;
          data_bus_addr = dst_reg;
          drive_en      = 1'b1;
          if (remaining_reg == COUNT_W'(1)) begin
            state_next = DONE;
          end else if (fill_sel) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Address/count bookkeeping and read-data capture, advanced only on granted cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_reg       <= '0;
      dst_reg       <= '0;
      remaining_reg <= '0;
      buffer_reg    <= '0;
    end else begin
      if (start_ok && (word_count != '0)) begin
        src_reg       <= src_addr;
        dst_reg       <= dst_addr;
        remaining_reg <= word_count;
      end
      if ((state_reg == READ) && bus_grant) begin
        buffer_reg <= data_bus_data;
      end
      if ((state_reg == WRITE) && bus_grant) begin
        src_reg       <= src_reg + ADDR_STRIDE;
        dst_reg       <= dst_reg + ADDR_STRIDE;
        remaining_reg <= remaining_reg - COUNT_W'(1);
      end
    end
  end

  // Active-low interrupt level: asserted leaving DONE, which beats a same-cycle ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_reg <= 1'b1;
    end else if (state_reg == DONE) begin
      irq_reg <= 1'b0;
    end else if (irq_ack || start_ok) begin
      irq_reg <= 1'b1;
    end
  end

  assign dma_irq = irq_reg;

  assign data_bus_data = drive_en ? write_data : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: directed checks of the DMA copy engine against a simple
// bus responder. Define DMA_FILL_EN to also exercise the fill feature.
// The responder holds the bus at zero while the bus is idle, so an engine that
// drives data without a write cycle shows up as a non-zero bus value.
module tb_dma_copy_engine;
  import dma_copy_engine_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] word_count;
  logic        irq_ack;
  logic        bus_grant;
  logic        bus_req;
  logic        busy;
  logic        done;
  logic        dma_irq;
  logic [31:0] data_bus_addr;
  logic [1:0]  data_bus_mode;
  wire  [31:0] data_bus_data;
`ifdef DMA_FILL_EN
  logic        fill_mode;
  logic [31:0] fill_value;
`endif

  int total = 0;
  int bad   = 0;

  dma_copy_engine #(
    .ADDR_STRIDE(32'd4),
    .COUNT_W    (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .word_count   (word_count),
    .irq_ack      (irq_ack),
`ifdef DMA_FILL_EN
    .fill_mode    (fill_mode),
    .fill_value   (fill_value),
`endif
    .bus_grant    (bus_grant),
    .bus_req      (bus_req),
    .busy         (busy),
    .done         (done),
    .dma_irq      (dma_irq),
    .data_bus_addr(data_bus_addr),
    .data_bus_mode(data_bus_mode),
    .data_bus_data(data_bus_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder memory contents returned on read cycles.
  logic [31:0] rd_word;
  always_comb begin
    case (data_bus_addr)
      32'h0000_1000: rd_word = 32'h0000_000A;
      32'h0000_1004: rd_word = 32'h0000_000B;
      32'h0000_1008: rd_word = 32'h0000_000C;
      32'hFFFF_FFFC: rd_word = 32'h1111_1111;
      32'h0000_0000: rd_word = 32'h2222_2222;
      default:       rd_word = 32'hBAD0_0000 ^ data_bus_addr;
    endcase
  end

  assign data_bus_data = (data_bus_mode == BUS_READ) ? rd_word :
                         ((data_bus_mode == BUS_IDLE) ? 32'h0000_0000 : 32'hzzzz_zzzz);

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Bus cycle check; data is only the engine's to drive outside read cycles.
  task automatic bus(input string tag, input logic [1:0] m, input logic [31:0] a, input logic [31:0] d);
    chk32({tag, " mode"}, {30'd0, data_bus_mode}, {30'd0, m});
    chk32({tag, " addr"}, data_bus_addr, a);
    if (m != BUS_READ) chk32({tag, " data"}, data_bus_data, d);
  endtask

  // Advance one clock; checks follow 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Pulse start for one edge; on return the engine is in cycle 1.
  task automatic go(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    src_addr   = s;
    dst_addr   = d;
    word_count = n;
    start      = 1'b1;
    tick();
    start = 1'b0;
    $display("txn start src=%h dst=%h count=%0d", s, d, n);
  endtask

  // One copied word with grant held high: read cycle then write cycle.
  task automatic word(input string tag, input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] v);
    bus({tag, " rd"}, BUS_READ, ra, 32'h0);
    tick();
    bus({tag, " wr"}, BUS_WRITE, wa, v);
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    irq_ack    = 1'b0;
    bus_grant  = 1'b1;
    src_addr   = '0;
    dst_addr   = '0;
    word_count = '0;
`ifdef DMA_FILL_EN
    fill_mode  = 1'b0;
    fill_value = '0;
`endif
    tick();
    tick();
    chk1("rst busy", busy, 1'b0);
    chk1("rst bus_req", bus_req, 1'b0);
    chk1("rst done", done, 1'b0);
    chk1("rst irq", dma_irq, 1'b1);
    bus("rst bus", BUS_IDLE, 32'h0, 32'h0);
    reset = 1'b0;
    tick();

    // Plain copy of three words, grant tied high.
    go(32'h1000, 32'h2000, 16'd3);
    chk1("t1 busy", busy, 1'b1);
    chk1("t1 bus_req", bus_req, 1'b1);
    word("t1 w0", 32'h1000, 32'h2000, 32'hA);
    word("t1 w1", 32'h1004, 32'h2004, 32'hB);
    word("t1 w2", 32'h1008, 32'h2008, 32'hC);
    chk1("t1 done c7", done, 1'b1);
    chk1("t1 irq c7", dma_irq, 1'b1);
    bus("t1 c7", BUS_IDLE, 32'h0, 32'h0);
    tick();
    chk1("t1 done c8", done, 1'b0);
    chk1("t1 irq c8", dma_irq, 1'b0);
    chk1("t1 busy c8", busy, 1'b0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk1("t1 irq acked", dma_irq, 1'b1);
    $display("txn copy3 checked");

    // Grant dropped for two cycles before the write of word 0.
    go(32'h1000, 32'h2100, 16'd1);
    bus("t2 rd", BUS_READ, 32'h1000, 32'h0);
    tick();
    bus_grant = 1'b0;
    #1;
    bus("t2 stall a", BUS_IDLE, 32'h0, 32'h0);
    chk1("t2 req stall", bus_req, 1'b1);
    tick();
    bus("t2 stall b", BUS_IDLE, 32'h0, 32'h0);
    tick();
    bus_grant = 1'b1;
    #1;
    bus("t2 wr", BUS_WRITE, 32'h2100, 32'hA);
    tick();
    chk1("t2 done c5", done, 1'b1);
    tick();
    chk1("t2 irq c6", dma_irq, 1'b0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk1("t2 irq acked", dma_irq, 1'b1);
    $display("txn stall checked");

    // Zero count: straight to DONE; an ack in the DONE cycle loses to it.
    go(32'h0, 32'h0, 16'd0);
    chk1("t3 done c1", done, 1'b1);
    chk1("t3 req c1", bus_req, 1'b0);
    bus("t3 c1", BUS_IDLE, 32'h0, 32'h0);
    irq_ack = 1'b1;
    tick();
    chk1("t3 irq c2", dma_irq, 1'b0);
    chk1("t3 done c2", done, 1'b0);
    tick();
    irq_ack = 1'b0;
    chk1("t3 irq acked", dma_irq, 1'b1);
    $display("txn zero-count checked");

    // A start while busy is ignored.
    go(32'h1000, 32'h2200, 16'd3);
    word("t4 w0", 32'h1000, 32'h2200, 32'hA);
    src_addr   = 32'h5000;
    dst_addr   = 32'h6000;
    word_count = 16'd7;
    start      = 1'b1;
    bus("t4 w1 rd", BUS_READ, 32'h1004, 32'h0);
    tick();
    start = 1'b0;
    bus("t4 w1 wr", BUS_WRITE, 32'h2204, 32'hB);
    tick();
    word("t4 w2", 32'h1008, 32'h2208, 32'hC);
    chk1("t4 done c7", done, 1'b1);
    tick();
    chk1("t4 done c8", done, 1'b0);
    chk1("t4 busy c8", busy, 1'b0);
    tick();
    chk1("t4 done c9", done, 1'b0);
    chk1("t4 busy c9", busy, 1'b0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    $display("txn ignored-start checked");

    // Reset in the write of word 1, then a fresh copy.
    go(32'h1000, 32'h2300, 16'd3);
    word("t5 w0", 32'h1000, 32'h2300, 32'hA);
    bus("t5 w1 rd", BUS_READ, 32'h1004, 32'h0);
    tick();
    bus("t5 w1 wr", BUS_WRITE, 32'h2304, 32'hB);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("t5 busy", busy, 1'b0);
    chk1("t5 req", bus_req, 1'b0);
    chk1("t5 done", done, 1'b0);
    chk1("t5 irq", dma_irq, 1'b1);
    bus("t5 after rst", BUS_IDLE, 32'h0, 32'h0);
    go(32'h1004, 32'h2400, 16'd1);
    word("t5 new", 32'h1004, 32'h2400, 32'hB);
    chk1("t5 done c3", done, 1'b1);
    tick();
    $display("txn reset-mid-copy checked");

    // Source address wraps past 2^32.
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    go(32'hFFFF_FFFC, 32'h2500, 16'd2);
    word("t6 w0", 32'hFFFF_FFFC, 32'h2500, 32'h1111_1111);
    word("t6 w1", 32'h0000_0000, 32'h2504, 32'h2222_2222);
    chk1("t6 done c5", done, 1'b1);
    tick();
    $display("txn wrap checked");

`ifdef DMA_FILL_EN
    // Fill: back-to-back write cycles only.
    fill_mode  = 1'b1;
    fill_value = 32'hDEAD_BEEF;
    go(32'h0, 32'h2600, 16'd4);
    fill_mode  = 1'b0;
    bus("t7 w0", BUS_WRITE, 32'h2600, 32'hDEAD_BEEF);
    tick();
    bus("t7 w1", BUS_WRITE, 32'h2604, 32'hDEAD_BEEF);
    tick();
    bus("t7 w2", BUS_WRITE, 32'h2608, 32'hDEAD_BEEF);
    tick();
    bus("t7 w3", BUS_WRITE, 32'h260C, 32'hDEAD_BEEF);
    tick();
    chk1("t7 done c5", done, 1'b1);
    tick();
    $display("txn fill checked");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
